// File: rtl/instr_fetch_unit_pkg.sv
// Shared core constants: opcodes, ALU op codes, fetch NOP/reset PC and fetch FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package instr_fetch_unit_pkg;

    // Canonical NOP: addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Major opcodes seen by the main controller
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    // Fetch FSM: issue a request, wait for its word, or park the word while stalled
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if_id_reg.sv
// IF/ID pipeline register with stall hold, flush/redirect bubble and word load.
// Latency: a load presented in cycle N is visible on the outputs in cycle N+1.
// Backpressure: stall_i holds contents; any cycle without stall or load inserts a bubble.
// Ports: clk/rst; stall_i, flush_i, bubble_i control; load_vld/load_instr/load_pc
//        new word; if_valid/if_instr/if_pc register outputs.
module fetch_if_id_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            bubble_i,
    input  logic            load_vld,
    input  logic [31:0]     load_instr,
    input  logic [XLEN-1:0] load_pc,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc
);

    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;

    // Flush/redirect win over everything; a load only ever arrives unstalled.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush_i || bubble_i) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (load_vld) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc_d    = load_pc;
        end else if (!stall_i) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign if_valid = valid_q;
    assign if_instr = instr_q;
    assign if_pc    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues one imem request at a time, fills IF/ID.
// Latency: word returned with imem_rvalid in cycle N appears on if_* in cycle N+1.
// Backpressure: stall_i parks a returned word in the hold buffer and blocks new requests.
// Ports: clk/rst; stall_i, flush_i, brn_taken_i/brn_target_i from downstream;
//        imem_req/imem_addr/imem_rvalid/imem_rdata memory side;
//        if_valid/if_instr/if_pc/if_opcode IF/ID outputs.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            brn_taken_i,
    input  logic [XLEN-1:0] brn_target_i,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [6:0]      if_opcode
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;       // in-flight response belongs to a redirected-away fetch
    logic [31:0]     hold_instr_q, hold_instr_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;

    logic            load_vld;
    logic [31:0]     load_instr;
    logic [XLEN-1:0] load_pc;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        load_vld     = 1'b0;
        load_instr   = hold_instr_q;
        load_pc      = hold_pc_q;

        if (brn_taken_i) begin
            pc_d = {brn_target_i[XLEN-1:2], 2'b00};
            case (state_q)
                ST_WAIT: begin
                    // A response arriving with the redirect is simply thrown away;
                    // otherwise the outstanding one must be dropped when it lands.
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    drop_d  = 1'b0;
                    state_d = ST_REQ;
                end
                default: begin
                    // REQ: the request going out this cycle is now stale
                    drop_d  = 1'b1;
                    state_d = ST_WAIT;
                end
            endcase
        end else begin
            case (state_q)
                ST_REQ: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = ST_REQ;
                        end else if (!stall_i) begin
                            load_vld   = 1'b1;
                            load_instr = imem_rdata;
                            load_pc    = pc_q;
                            pc_d       = pc_q + XLEN'(4);
                            state_d    = ST_REQ;
                        end else begin
                            hold_instr_d = imem_rdata;
                            hold_pc_d    = pc_q;
                            state_d      = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall_i) begin
                        load_vld = 1'b1;
                        pc_d     = pc_q + XLEN'(4);
                        state_d  = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            hold_instr_q <= NOP_INSTR;
            hold_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    // Request strobe decoded from the state flop; masked while reset is held so the
    // first request appears in the cycle reset is released.
    assign imem_req  = (state_q == ST_REQ) && !rst;
    assign imem_addr = pc_q;

    fetch_if_id_reg #(
        .XLEN(XLEN)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .bubble_i   (brn_taken_i),
        .load_vld   (load_vld),
        .load_instr (load_instr),
        .load_pc    (load_pc),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc)
    );

    assign if_opcode = opcode_of(if_instr);

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, flush_i, brn_taken_i;
    logic [31:0] brn_target_i;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;
    logic [6:0]  if_opcode;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model: responds mem_lat cycles after the request cycle
    int          mem_lat  = 1;
    bit          pend     = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .brn_taken_i  (brn_taken_i),
        .brn_target_i (brn_target_i),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_opcode    (if_opcode)
    );

    // Word at 0x0 is addi x1,x0,5; every other address returns {addr[24:0], OP opcode}
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[24:0], 7'b0110011};
    endfunction

    // Advance one clock; sample outputs 1ns after the edge and drive the memory response
    task automatic step();
        bit          req_seen;
        logic [31:0] a;
        req_seen = imem_req;
        a        = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (req_seen) begin
                pend      = 1'b1;
                pend_cnt  = mem_lat;
                pend_addr = a;
            end
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(pend_addr);
                    pend        = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; brn_taken_i = 1'b0;
        brn_target_i = '0; imem_rvalid = 1'b0; imem_rdata = '0;
        step(); step();
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", if_valid); end
        n_checks++; if (if_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL rst_instr: got %h want 00000013", if_instr); end
        n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", if_pc); end
        n_checks++; if (if_opcode !== 7'b0010011) begin n_fail++; $display("FAIL rst_opcode: got %b want 0010011", if_opcode); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
        rst = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rel_req: got %b want 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rel_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_sequential();
        step();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_wait_req: got %b want 0", imem_req); end
        step();
        n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid0: got %b want 1", if_valid); end
        n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL seq_pc0: got %h want 0", if_pc); end
        n_checks++; if (if_instr !== 32'h0050_0093) begin n_fail++; $display("FAIL seq_instr0: got %h want 00500093", if_instr); end
        n_checks++; if (if_opcode !== 7'b0010011) begin n_fail++; $display("FAIL seq_opc0: got %b want 0010011", if_opcode); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL seq_addr4: got req=%b addr=%h want 1/4", imem_req, imem_addr); end
        step();
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL seq_bubble: got %b want 0", if_valid); end
        step();
        n_checks++; if (if_pc !== 32'h4 || if_instr !== 32'h0000_0233) begin n_fail++; $display("FAIL seq_word4: got pc=%h instr=%h want 4/00000233", if_pc, if_instr); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL seq_addr8: got req=%b addr=%h want 1/8", imem_req, imem_addr); end
    endtask

    task automatic test_stall();
        stall_i = 1'b1;
        step();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin n_fail++; $display("FAIL stall_keep1: got v=%b pc=%h want 1/4", if_valid, if_pc); end
        step();
        n_checks++; if (dut.state_q !== ST_HOLD) begin n_fail++; $display("FAIL stall_hold: got %0d want %0d", dut.state_q, ST_HOLD); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req: got %b want 0", imem_req); end
        n_checks++; if (if_instr !== 32'h0000_0233) begin n_fail++; $display("FAIL stall_keep2: got %h want 00000233", if_instr); end
        step();
        n_checks++; if (dut.state_q !== ST_HOLD || imem_req !== 1'b0 || if_pc !== 32'h4) begin n_fail++; $display("FAIL stall_keep3: got st=%0d req=%b pc=%h want HOLD/0/4", dut.state_q, imem_req, if_pc); end
        stall_i = 1'b0;
        step();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== 32'h0000_0433) begin n_fail++; $display("FAIL stall_release: got v=%b pc=%h instr=%h want 1/8/00000433", if_valid, if_pc, if_instr); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL stall_addrC: got req=%b addr=%h want 1/c", imem_req, imem_addr); end
    endtask

    task automatic test_branch_wait();
        mem_lat = 3;
        step();
        brn_taken_i = 1'b1; brn_target_i = 32'h0000_0103;
        step();
        brn_taken_i = 1'b0;
        n_checks++; if (dut.drop_q !== 1'b1) begin n_fail++; $display("FAIL brw_drop_set: got %b want 1", dut.drop_q); end
        n_checks++; if (dut.pc_q !== 32'h100) begin n_fail++; $display("FAIL brw_pc: got %h want 100", dut.pc_q); end
        n_checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL brw_idle: got req=%b v=%b want 0/0", imem_req, if_valid); end
        step();
        n_checks++; if (imem_rvalid !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL brw_stale_resp: got rv=%b req=%b want 1/0", imem_rvalid, imem_req); end
        step();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL brw_addr: got req=%b addr=%h want 1/100", imem_req, imem_addr); end
        n_checks++; if (if_valid !== 1'b0 || dut.drop_q !== 1'b0) begin n_fail++; $display("FAIL brw_dropped: got v=%b drop=%b want 0/0", if_valid, dut.drop_q); end
        mem_lat = 1;
        step();
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL brw_still_bubble: got %b want 0", if_valid); end
        step();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'h0000_8033) begin n_fail++; $display("FAIL brw_word: got v=%b pc=%h instr=%h want 1/100/00008033", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_branch_coincident();
        step();
        brn_taken_i = 1'b1; brn_target_i = 32'h0000_0200;
        step();
        brn_taken_i = 1'b0;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL brc_addr: got req=%b addr=%h want 1/200", imem_req, imem_addr); end
        n_checks++; if (dut.drop_q !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL brc_nodrop: got drop=%b v=%b want 0/0", dut.drop_q, if_valid); end
        step(); step();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== 32'h0001_0033) begin n_fail++; $display("FAIL brc_word: got v=%b pc=%h instr=%h want 1/200/00010033", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_flush();
        stall_i = 1'b1; flush_i = 1'b1;
        step();
        flush_i = 1'b0; stall_i = 1'b0;
        n_checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL flush_bubble: got v=%b instr=%h want 0/00000013", if_valid, if_instr); end
        n_checks++; if (dut.pc_q !== 32'h204 || dut.state_q !== ST_WAIT) begin n_fail++; $display("FAIL flush_pc: got pc=%h st=%0d want 204/WAIT", dut.pc_q, dut.state_q); end
        step();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h204 || if_instr !== 32'h0001_0233) begin n_fail++; $display("FAIL flush_resume: got v=%b pc=%h instr=%h want 1/204/00010233", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_reset_mid();
        brn_taken_i = 1'b1; brn_target_i = 32'hFFFF_FFFB;
        step();
        brn_taken_i = 1'b0;
        step();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL rm_align: got req=%b addr=%h want 1/fffffff8", imem_req, imem_addr); end
        step(); step();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFF8 || if_instr !== 32'hFFFF_FC33) begin n_fail++; $display("FAIL rm_word: got v=%b pc=%h instr=%h want 1/fffffff8/fffffc33", if_valid, if_pc, if_instr); end
        mem_lat = 3; stall_i = 1'b1;
        step();
        n_checks++; if (dut.state_q !== ST_WAIT || dut.pc_q !== 32'hFFFF_FFFC || if_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pre: got st=%0d pc=%h v=%b want WAIT/fffffffc/1", dut.state_q, dut.pc_q, if_valid); end
        rst = 1'b1;
        #1;
        n_checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL rm_async_if: got v=%b instr=%h want 0/00000013", if_valid, if_instr); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rm_async_req: got %b want 0", imem_req); end
        step(); step();
        mem_lat = 1; stall_i = 1'b0; rst = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_restart: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        brn_taken_i = 1'b1; brn_target_i = 32'hFFFF_FFFC;
        step();
        brn_taken_i = 1'b0;
        step();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req: got req=%b addr=%h want 1/fffffffc", imem_req, imem_addr); end
        step(); step();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_instr !== 32'hFFFF_FE33) begin n_fail++; $display("FAIL wrap_word: got v=%b pc=%h instr=%h want 1/fffffffc/fffffe33", if_valid, if_pc, if_instr); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_wait();
        test_branch_coincident();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before the end of test");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the RISC-V core. It owns the program counter and issues one request at a time to instruction memory. It holds the returned word in the IF/ID register, whose `if_opcode` field drives the main controller's `opcode` input. It also absorbs pipeline stalls, flushes and taken-branch redirects from downstream.

## Interface
Parameters:
- `XLEN`, 32, address/PC width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  core clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `stall_i`  in  1  hazard unit: hold IF/ID contents this cycle
- `flush_i`  in  1  kill IF/ID contents (bubble), PC unchanged
- `brn_taken_i`  in  1  one-cycle pulse from execute: redirect fetch
- `brn_target_i`  in  XLEN  redirect address
- `imem_req`  out  1  request strobe; accepted in the cycle it is high
- `imem_addr`  out  XLEN  request address, word aligned
- `imem_rvalid`  in  1  response strobe, at least 1 cycle after `imem_req`
- `imem_rdata`  in  32  instruction word
- `if_valid`  out  1  IF/ID holds a real instruction
- `if_instr`  out  32  IF/ID instruction; NOP 32'h0000_0013 when `if_valid`=0
- `if_pc`  out  XLEN  PC of `if_instr`
- `if_opcode`  out  7  `if_instr[6:0]`, to main controller

## Operation
- FSM states are REQ, WAIT and HOLD. Only one request is outstanding at any time.
- REQ:
  - `imem_req`=1, `imem_addr`=pc.
  - Next state is always WAIT.
  - `imem_rvalid` in REQ is ignored.
- WAIT:
  - `imem_req`=0.
  - On `imem_rvalid` with the drop flag set: clear the drop flag, discard the word, go to REQ.
  - On `imem_rvalid` with `stall_i`=0: load IF/ID with {1, rdata, pc}, pc += 4, go to REQ.
  - On `imem_rvalid` with `stall_i`=1: capture {rdata, pc} in the hold buffer, go to HOLD.
- HOLD:
  - `imem_req`=0.
  - When `stall_i`=0: move the hold buffer into IF/ID, pc += 4, go to REQ.
- IF/ID update rule:
  - When `stall_i`=0 and no new word is loaded this cycle, IF/ID becomes a bubble: `if_valid`=0, `if_instr`=NOP.
  - When `stall_i`=1, IF/ID keeps its contents.
- `flush_i`: IF/ID becomes a bubble next cycle regardless of `stall_i`. The hold buffer, pc and FSM state are untouched.
- `brn_taken_i` has priority over everything except `rst`:
  - pc := `brn_target_i` with bits [1:0] forced to 0.
  - IF/ID becomes a bubble and the hold buffer is discarded.
  - From REQ (request just issued) or from WAIT without `imem_rvalid`: set the drop flag, go to WAIT.
  - From WAIT with `imem_rvalid` in the same cycle: discard the word, go to REQ.
  - From HOLD: go to REQ.
- PC arithmetic wraps modulo 2^XLEN.
- Reset values:
  - state=REQ, pc=`RESET_PC`, drop flag=0.
  - `if_valid`=0, `if_instr`=NOP, `if_pc`=0, `if_opcode`=7'b0010011.
  - `imem_req`=0 while `rst` is high; `imem_req` rises in the first cycle after `rst` falls.
- Reset asserted mid-request: all state clears at once. A late `imem_rvalid` after reset is discarded only if it arrives in REQ; the memory must not respond to pre-reset requests once reset releases.

## Timing
- `imem_req`/`imem_addr` are registered outputs decoded from state and pc.
- Latency: a word returned with `imem_rvalid` at cycle N appears on `if_*` at cycle N+1.
- Peak throughput is one instruction per 2 cycles with a 1-cycle memory.
- A redirect pulse at cycle N issues `imem_addr`=target no earlier than cycle N+1. If the memory response arrives in the same cycle N, the request is issued at N+1. If the drop flag is set, the request is issued one cycle after the dropped response.
- `if_opcode` is combinational from `if_instr`.

## Structure
- Shared constants header (alongside the opcode and ALU constants): `NOP_INSTR`, `RESET_PC` default, and the fetch FSM state encodings.
- One sub-module, `fetch_if_id_reg`: the IF/ID register with stall/flush/bubble load logic. The PC, FSM, hold buffer and drop flag stay in the top level.

## Test plan
- Reset release, 1-cycle memory returning 32'h00500093 at 0x0 → `imem_addr` sequence 0x0, 0x4, 0x8 on alternate cycles; `if_pc`=0, `if_instr`=32'h00500093, `if_opcode`=7'b0010011, `if_valid`=1.
- `stall_i` held high 3 cycles while the word for 0x8 returns → IF/ID keeps the 0x4 instruction; state HOLD; no `imem_req`; 0x8 appears one cycle after `stall_i` falls, then `imem_addr`=0xC.
- `brn_taken_i` with target 0x103 while in WAIT, response 2 cycles later → stale word dropped; next `imem_addr`=0x100; `if_valid`=0 until the 0x100 word arrives.
- `brn_taken_i` coincident with `imem_rvalid` → word discarded; `imem_addr`=target next cycle; drop flag stays 0.
- `flush_i` with `stall_i`=1 → `if_valid`=0, `if_instr`=NOP next cycle; pc unchanged; fetch continues.
- `rst` asserted in WAIT with pc=0xFFFF_FFFC → immediate `if_valid`=0 and `imem_req`=0; after release `imem_addr`=`RESET_PC`. Separately, fetch at 0xFFFF_FFFC → next pc wraps to 0x0.
